// File: rtl/fft_stage_sequencer.sv
// Per-beat control stream for a 4-lane radix-2 FFT butterfly array: walks stages and groups of an N-point transform.
// Outputs come straight from state registers (first beat one cycle after start); a beat advances only when i_ready accepts it, otherwise everything holds.
module fft_stage_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_start,
   input  logic [2:0]  i_point_configuration,
   input  logic        i_ready,
   output logic [2:0]  o_point_configuration,
   output logic [2:0]  o_stage,
   output logic [10:0] o_stride,
   output logic        o_beat_valid,
   output logic [3:0]  o_lane_valid,
   output logic        o_new_stage_trigger,
   output logic        o_group_done,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic [2:0] cfg_q, cfg_d;
   logic [2:0] stage_q, stage_d;
   logic [5:0] beat_q, beat_d;
   logic [5:0] last_beat;
   logic [6:0] beat_num;
   logic [6:0] group_mask;
   logic       run;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cfg_q   <= 3'd0;
         stage_q <= 3'd0;
         beat_q  <= 6'd0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         stage_q <= stage_d;
         beat_q  <= beat_d;
      end
   end

   // Beats per stage is 2^(cfg-2), floored at a single beat for 2- and 4-point transforms.
   assign last_beat = (cfg_q < 3'd2) ? 6'd0 : 6'((7'd1 << (cfg_q - 3'd2)) - 7'd1);

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      stage_d = stage_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = RUN;
               cfg_d   = i_point_configuration;
               stage_d = 3'd0;
               beat_d  = 6'd0;
            end
         end
         RUN: begin
            if (i_ready) begin
               if (beat_q == last_beat) begin
                  beat_d = 6'd0;
                  if (stage_q == cfg_q) begin
                     state_d = DONE;
                     stage_d = 3'd0;
                  end else begin
                     stage_d = stage_q + 3'd1;
                  end
               end else begin
                  beat_d = beat_q + 6'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign run = (state_q == RUN);

   // Groups of stride butterflies span stride/4 beats once stride reaches 4; below that every beat closes a group.
   assign beat_num   = {1'b0, beat_q} + 7'd1;
   assign group_mask = (stage_q < 3'd2) ? 7'd0 : ((7'd1 << (stage_q - 3'd2)) - 7'd1);

   assign o_point_configuration = (state_q == IDLE) ? 3'd0 : cfg_q;
   assign o_stage               = stage_q;
   assign o_stride              = 11'd1 << stage_q;
   assign o_beat_valid          = run;
   assign o_busy                = run;
   assign o_done                = (state_q == DONE);
   assign o_new_stage_trigger   = run && (beat_q == 6'd0);
   assign o_group_done          = run && ((beat_num & group_mask) == 7'd0);
   assign o_lane_valid          = !run           ? 4'b0000 :
                                  (cfg_q >= 3'd2) ? 4'b1111 :
                                  (cfg_q == 3'd1) ? 4'b0011 : 4'b0001;

endmodule
